// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 read-port arbiter.
//   arb_state_t : command state machine encoding
//   arb_tag_t   : {id, burstcount} ownership record of one accepted burst,
//                 sized for the widest configuration (8 masters, 11-bit
//                 Avalon burstcount); instances narrow it as needed.
package ddr3_arb_pkg;

  localparam int DDR3_ADDR_W = 27;
  localparam int DDR3_DATA_W = 256;
  localparam int TAG_ID_W    = 3;
  localparam int TAG_BURST_W = 11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [TAG_ID_W-1:0]    id;
    logic [TAG_BURST_W-1:0] burstcount;
  } arb_tag_t;

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// Show-ahead single-clock FIFO holding the owner tag of every burst that
// the DDR3 controller has accepted but not yet fully returned.
// Ports:
//   ddr3clk : clock
//   clr     : synchronous clear, empties the FIFO
//   push    : write wdata at the tail
//   wdata   : tag to write
//   pop     : discard the head entry
//   rdata   : head entry, valid whenever empty is low (no read latency)
//   empty   : no entries held
//   used    : number of entries held (0..depth)
// depth must be a power of two; pointers wrap naturally.
module ddr3_arb_tag_fifo
  import ddr3_arb_pkg::*;
#(
  parameter int depth = 8,
  parameter int width = 6
) (
  input  logic                   ddr3clk,
  input  logic                   clr,
  input  logic                   push,
  input  logic [width-1:0]       wdata,
  input  logic                   pop,
  output logic [width-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(depth):0] used
);

  localparam int PTR_W = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge ddr3clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge ddr3clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (used == '0);

endmodule

// File: rtl/ddr3_read_arbiter.sv
// Shares one 256-bit Avalon-MM DDR3 read port between num_masters
// burst-read masters. Commands are granted one at a time with rotating
// priority; the owner of every accepted burst is queued so that returning
// beats are steered back to their master in issue order.
// Ports:
//   ddr3clk, ddr3clk_reset  : clock, synchronous active-high reset
//   m_address/m_read/m_burstcount : per-master command inputs (packed)
//   m_waitrequest           : per-master stall, low only on acceptance
//   m_readdatavalid         : per-master return strobe (combinational)
//   m_readdata              : return data broadcast to every master
//   ddr3_address/ddr3_read/ddr3_burstcount/ddr3_waitrequest : command port
//   ddr3_readdatavalid/ddr3_readdata : controller return path
//   outstanding             : accepted bursts not yet fully returned
//   err_sticky              : zero-length request or orphan beat seen
// burst_width must not exceed the package TAG_BURST_W.
module ddr3_read_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int num_masters     = 2,
  parameter int max_outstanding = 8,
  parameter int burst_width     = 5
) (
  input  logic                                 ddr3clk,
  input  logic                                 ddr3clk_reset,
  input  logic [num_masters*DDR3_ADDR_W-1:0]   m_address,
  input  logic [num_masters-1:0]               m_read,
  input  logic [num_masters*burst_width-1:0]   m_burstcount,
  output logic [num_masters-1:0]               m_waitrequest,
  output logic [num_masters-1:0]               m_readdatavalid,
  output logic [DDR3_DATA_W-1:0]               m_readdata,
  output logic [DDR3_ADDR_W-1:0]               ddr3_address,
  output logic                                 ddr3_read,
  output logic [burst_width-1:0]               ddr3_burstcount,
  input  logic                                 ddr3_waitrequest,
  input  logic                                 ddr3_readdatavalid,
  input  logic [DDR3_DATA_W-1:0]               ddr3_readdata,
  output logic [$clog2(max_outstanding):0]     outstanding,
  output logic                                 err_sticky
);

  localparam int ID_W  = $clog2(num_masters);
  localparam int CNT_W = $clog2(max_outstanding) + 1;
  localparam int TAG_W = ID_W + burst_width;

  arb_state_t             state;
  arb_state_t             state_nxt;
  logic [ID_W-1:0]        grant;
  logic [ID_W-1:0]        grant_nxt;
  logic [ID_W-1:0]        last_grant;

  logic [num_masters-1:0] req_ok;
  logic                   zero_req;
  logic                   sel_found;
  logic [ID_W-1:0]        sel_idx;
  logic                   full;
  logic                   push;

  logic [TAG_W-1:0]       fifo_wdata;
  logic [TAG_W-1:0]       fifo_rdata;
  logic                   fifo_empty;
  arb_tag_t               head_tag;
  logic [TAG_BURST_W-1:0] beat_rem;
  logic [TAG_BURST_W-1:0] cur_rem;
  logic                   beat_ok;
  logic                   last_beat;

  assign full = (outstanding == CNT_W'(max_outstanding));

  // Eligible requesters and rotating search starting after last_grant.
  // A request with burstcount 0 is never eligible; it only flags an error.
  always_comb begin
    req_ok    = '0;
    zero_req  = 1'b0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < num_masters; i++) begin
      if (m_read[i]) begin
        if (m_burstcount[i*burst_width +: burst_width] != '0) begin
          req_ok[i] = 1'b1;
        end else begin
          zero_req = 1'b1;
        end
      end
    end
    for (int k = 1; k <= num_masters; k++) begin
      for (int i = 0; i < num_masters; i++) begin
        if (!sel_found && req_ok[i] &&
            (i == (int'(last_grant) + k) % num_masters)) begin
          sel_found = 1'b1;
          sel_idx   = ID_W'(i);
        end
      end
    end
  end

  // Command port is a plain mux of the granted master.
  always_comb begin
    ddr3_address    = '0;
    ddr3_burstcount = '0;
    for (int i = 0; i < num_masters; i++) begin
      if (grant == ID_W'(i)) begin
        ddr3_address    = m_address[i*DDR3_ADDR_W +: DDR3_ADDR_W];
        ddr3_burstcount = m_burstcount[i*burst_width +: burst_width];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    push      = 1'b0;
    ddr3_read = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!full && sel_found) begin
          grant_nxt = sel_idx;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ddr3_read = 1'b1;
        if (!ddr3_waitrequest) begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ddr3clk) begin
    if (ddr3clk_reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= ID_W'(num_masters - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (push) begin
        last_grant <= grant;
      end
    end
  end

  // The granted master sees its acceptance in the same cycle as the
  // controller, so it can move on to its next command immediately.
  always_comb begin
    for (int i = 0; i < num_masters; i++) begin
      m_waitrequest[i] = !((state == ST_ISSUE) && (grant == ID_W'(i)) &&
                           !ddr3_waitrequest);
    end
  end

  assign fifo_wdata = {grant, ddr3_burstcount};

  ddr3_arb_tag_fifo #(
    .depth (max_outstanding),
    .width (TAG_W)
  ) u_tag_fifo (
    .ddr3clk (ddr3clk),
    .clr     (ddr3clk_reset),
    .push    (push),
    .wdata   (fifo_wdata),
    .pop     (last_beat),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty),
    .used    (outstanding)
  );

  // beat_rem == 0 means "not yet loaded": the head's burstcount is used
  // directly, which lets a new head take over on the very next beat after
  // a pop without a dead cycle.
  always_comb begin
    head_tag            = '0;
    head_tag.id         = TAG_ID_W'(fifo_rdata[TAG_W-1 -: ID_W]);
    head_tag.burstcount = TAG_BURST_W'(fifo_rdata[burst_width-1:0]);
    cur_rem   = (beat_rem == '0) ? head_tag.burstcount : beat_rem;
    beat_ok   = ddr3_readdatavalid && !fifo_empty;
    last_beat = beat_ok && (cur_rem == TAG_BURST_W'(1));
  end

  always_comb begin
    for (int i = 0; i < num_masters; i++) begin
      m_readdatavalid[i] = beat_ok && (head_tag.id == TAG_ID_W'(i));
    end
  end

  assign m_readdata = ddr3_readdata;

  always_ff @(posedge ddr3clk) begin
    if (ddr3clk_reset) begin
      beat_rem   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (beat_ok) begin
        beat_rem <= last_beat ? '0 : (cur_rem - 1'b1);
      end
      if ((ddr3_readdatavalid && fifo_empty) || zero_req) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_read_arbiter.sv
module tb_ddr3_read_arbiter;

  localparam int NM   = 2;
  localparam int MAXO = 8;
  localparam int BW   = 5;
  localparam int AW   = 27;
  localparam int DW   = 256;
  localparam int CW   = $clog2(MAXO) + 1;

  logic              ddr3clk = 1'b0;
  logic              ddr3clk_reset = 1'b1;
  logic [NM*AW-1:0]  m_address = '0;
  logic [NM-1:0]     m_read = '0;
  logic [NM*BW-1:0]  m_burstcount = '0;
  logic [NM-1:0]     m_waitrequest;
  logic [NM-1:0]     m_readdatavalid;
  logic [DW-1:0]     m_readdata;
  logic [AW-1:0]     ddr3_address;
  logic              ddr3_read;
  logic [BW-1:0]     ddr3_burstcount;
  logic              ddr3_waitrequest = 1'b0;
  logic              ddr3_readdatavalid = 1'b0;
  logic [DW-1:0]     ddr3_readdata = '0;
  logic [CW-1:0]     outstanding;
  logic              err_sticky;

  always #5 ddr3clk = ~ddr3clk;

  ddr3_read_arbiter #(
    .num_masters     (NM),
    .max_outstanding (MAXO),
    .burst_width     (BW)
  ) dut (
    .ddr3clk            (ddr3clk),
    .ddr3clk_reset      (ddr3clk_reset),
    .m_address          (m_address),
    .m_read             (m_read),
    .m_burstcount       (m_burstcount),
    .m_waitrequest      (m_waitrequest),
    .m_readdatavalid    (m_readdatavalid),
    .m_readdata         (m_readdata),
    .ddr3_address       (ddr3_address),
    .ddr3_read          (ddr3_read),
    .ddr3_burstcount    (ddr3_burstcount),
    .ddr3_waitrequest   (ddr3_waitrequest),
    .ddr3_readdatavalid (ddr3_readdatavalid),
    .ddr3_readdata      (ddr3_readdata),
    .outstanding        (outstanding),
    .err_sticky         (err_sticky)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a command being presented (pend), the queue of accepted
  // bursts in issue order, and how many beats of the head have returned.
  int pend = -1;
  int last_g = NM - 1;
  int head_done = 0;
  int q_id[$];
  int q_bc[$];
  bit err = 1'b0;
  bit mon_en = 1'b0;

  int glog[$];
  int rlog[$];
  int rdv_cnt[NM];
  bit acc[NM];

  function automatic int beats_left();
    int s;
    s = 0;
    foreach (q_bc[j]) s += q_bc[j];
    return s - head_done;
  endfunction

  always @(negedge ddr3clk) begin
    logic [NM-1:0] exp_wr;
    logic [NM-1:0] exp_rdv;
    int size0;
    int idx;
    bit found;
    if (mon_en) begin
      exp_wr  = '1;
      exp_rdv = '0;
      for (int i = 0; i < NM; i++) begin
        if (pend == i && !ddr3_waitrequest) exp_wr[i] = 1'b0;
        if (ddr3_readdatavalid && q_id.size() > 0) begin
          if (q_id[0] == i) exp_rdv[i] = 1'b1;
        end
      end
      chk("ddr3_read", DW'(ddr3_read), DW'(pend >= 0));
      if (pend >= 0) begin
        chk("ddr3_address", DW'(ddr3_address), DW'(m_address[pend*AW +: AW]));
        chk("ddr3_burstcount", DW'(ddr3_burstcount), DW'(m_burstcount[pend*BW +: BW]));
      end
      chk("m_waitrequest", DW'(m_waitrequest), DW'(exp_wr));
      chk("m_readdatavalid", DW'(m_readdatavalid), DW'(exp_rdv));
      chk("m_readdata", m_readdata, ddr3_readdata);
      chk("outstanding", DW'(outstanding), DW'(q_id.size()));
      chk("err_sticky", DW'(err_sticky), DW'(err));

      for (int i = 0; i < NM; i++) begin
        if (!m_waitrequest[i]) begin
          acc[i] = 1'b1;
          glog.push_back(i);
        end
        if (m_readdatavalid[i]) begin
          rdv_cnt[i]++;
          rlog.push_back(i);
        end
      end

      if (ddr3clk_reset) begin
        pend = -1;
        last_g = NM - 1;
        head_done = 0;
        q_id.delete();
        q_bc.delete();
        err = 1'b0;
      end else begin
        size0 = q_id.size();
        if (ddr3_readdatavalid) begin
          if (size0 == 0) begin
            err = 1'b1;
          end else begin
            head_done++;
            if (head_done == q_bc[0]) begin
              void'(q_id.pop_front());
              void'(q_bc.pop_front());
              head_done = 0;
            end
          end
        end
        for (int i = 0; i < NM; i++) begin
          if (m_read[i] && m_burstcount[i*BW +: BW] == '0) err = 1'b1;
        end
        if (pend >= 0) begin
          if (!ddr3_waitrequest) begin
            q_id.push_back(pend);
            q_bc.push_back(int'(m_burstcount[pend*BW +: BW]));
            last_g = pend;
            pend = -1;
          end
        end else if (size0 < MAXO) begin
          found = 1'b0;
          for (int k = 1; k <= NM; k++) begin
            idx = (last_g + k) % NM;
            if (!found && m_read[idx] && m_burstcount[idx*BW +: BW] != '0) begin
              found = 1'b1;
              pend = idx;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge ddr3clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input int bc);
    m_address[m*AW +: AW]    = a;
    m_burstcount[m*BW +: BW] = BW'(bc);
    m_read[m]                = 1'b1;
  endtask

  task automatic issue(input int m, input logic [AW-1:0] a, input int bc);
    acc[m] = 1'b0;
    set_req(m, a, bc);
    for (int c = 0; c < 100; c++) begin
      tick();
      if (acc[m]) break;
    end
    m_read[m] = 1'b0;
    if (!acc[m]) chk("issue_timeout", 0, 1);
  endtask

  task automatic beats(input int n);
    for (int b = 0; b < n; b++) begin
      ddr3_readdatavalid = 1'b1;
      ddr3_readdata = {8{$urandom}};
      tick();
    end
    ddr3_readdatavalid = 1'b0;
  endtask

  task automatic do_reset(input int cyc);
    ddr3clk_reset = 1'b1;
    repeat (cyc) tick();
    ddr3clk_reset = 1'b0;
  endtask

  task automatic clr_cnt();
    foreach (rdv_cnt[i]) rdv_cnt[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int ones;
    int tot;
    clr_cnt();
    foreach (acc[i]) acc[i] = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    ddr3clk_reset = 1'b0;

    // Reset values
    chk("rst_ddr3_read", DW'(ddr3_read), 0);
    chk("rst_m_waitrequest", DW'(m_waitrequest), DW'(2'b11));
    chk("rst_m_readdatavalid", DW'(m_readdatavalid), 0);
    chk("rst_outstanding", DW'(outstanding), 0);
    chk("rst_err_sticky", DW'(err_sticky), 0);

    // Single burst
    clr_cnt();
    issue(0, 27'h100, 15);
    chk("single_out_1", DW'(outstanding), 1);
    beats(15);
    chk("single_m0_beats", DW'(rdv_cnt[0]), 15);
    chk("single_m1_beats", DW'(rdv_cnt[1]), 0);
    chk("single_out_0", DW'(outstanding), 0);

    // Fairness after reset: both hold requests continuously
    do_reset(2);
    glog.delete();
    clr_cnt();
    set_req(0, 27'h200, 15);
    set_req(1, 27'h300, 15);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (glog.size() >= 4) break;
    end
    m_read = '0;
    chk("fair_ngrants", DW'(glog.size()), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < glog.size()) chk($sformatf("fair_grant%0d", j), DW'(glog[j]), DW'(j % 2));
    end
    chk("fair_out", DW'(outstanding), 4);
    beats(60);
    chk("fair_m0_beats", DW'(rdv_cnt[0]), 30);
    chk("fair_m1_beats", DW'(rdv_cnt[1]), 30);

    // Interleaved returns with back-to-back burst handoffs
    rlog.delete();
    issue(0, 27'h400, 15);
    issue(1, 27'h500, 4);
    issue(0, 27'h600, 2);
    beats(21);
    chk("intl_nbeats", DW'(rlog.size()), 21);
    for (int j = 0; j < 21; j++) begin
      if (j < rlog.size())
        chk($sformatf("intl_beat%0d", j), DW'(rlog[j]), DW'((j >= 15 && j < 19) ? 1 : 0));
    end

    // Full: eight single-beat bursts, then a ninth request must stall
    for (int j = 0; j < 8; j++) issue(j % 2, AW'(j * 16), 1);
    chk("full_out_8", DW'(outstanding), 8);
    g0 = glog.size();
    set_req(0, 27'h700, 1);
    repeat (6) tick();
    chk("full_no_read", DW'(ddr3_read), 0);
    chk("full_m0_wait", DW'(m_waitrequest[0]), 1);
    chk("full_no_grant", DW'(glog.size()), DW'(g0));
    ddr3_readdatavalid = 1'b1;
    tick();
    ddr3_readdatavalid = 1'b0;
    tick();
    chk("full_reissue", DW'(ddr3_read), 1);
    ddr3_readdatavalid = 1'b1;
    tick();
    ddr3_readdatavalid = 1'b0;
    m_read[0] = 1'b0;
    chk("simul_push_pop_out", DW'(outstanding), 7);
    beats(7);
    chk("drain_out_0", DW'(outstanding), 0);

    // Orphan beat
    chk("err_clear_before", DW'(err_sticky), 0);
    clr_cnt();
    beats(1);
    chk("orphan_err", DW'(err_sticky), 1);
    chk("orphan_no_rdv", DW'(rdv_cnt[0] + rdv_cnt[1]), 0);

    // Zero burstcount on master 1 is skipped and flagged
    do_reset(1);
    chk("err_after_reset", DW'(err_sticky), 0);
    glog.delete();
    set_req(1, 27'h800, 0);
    repeat (8) tick();
    chk("zero_err", DW'(err_sticky), 1);
    issue(0, 27'h900, 2);
    m_read[1] = 1'b0;
    ones = 0;
    foreach (glog[j]) if (glog[j] == 1) ones++;
    chk("zero_never_granted", DW'(ones), 0);
    chk("zero_m0_granted", DW'(glog.size()), 1);
    beats(2);

    // Reset mid-burst
    issue(0, 27'hA00, 15);
    beats(3);
    ddr3clk_reset = 1'b1;
    tick();
    ddr3clk_reset = 1'b0;
    chk("mid_rst_read", DW'(ddr3_read), 0);
    chk("mid_rst_wait", DW'(m_waitrequest), DW'(2'b11));
    chk("mid_rst_rdv", DW'(m_readdatavalid), 0);
    chk("mid_rst_out", DW'(outstanding), 0);
    chk("mid_rst_err", DW'(err_sticky), 0);
    glog.delete();
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    set_req(0, 27'hB00, 3);
    set_req(1, 27'hC00, 3);
    for (int c = 0; c < 100; c++) begin
      tick();
      for (int i = 0; i < NM; i++) if (acc[i]) m_read[i] = 1'b0;
      if (acc[0] && acc[1]) break;
    end
    m_read = '0;
    chk("mid_rst_first_grant", DW'((glog.size() > 0) ? glog[0] : -1), 0);
    beats(6);

    // Randomized traffic against the reference
    foreach (acc[i]) acc[i] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (acc[i]) begin
          m_read[i] = 1'b0;
          acc[i] = 1'b0;
        end
        if (!m_read[i] && ($urandom % 3 == 0))
          set_req(i, AW'($urandom), 1 + int'($urandom % 8));
      end
      ddr3_waitrequest = ($urandom % 4 == 0);
      if (beats_left() > 0 && ($urandom % 3 != 0)) begin
        ddr3_readdatavalid = 1'b1;
        ddr3_readdata = {8{$urandom}};
      end else begin
        ddr3_readdatavalid = 1'b0;
      end
      tick();
    end
    ddr3_waitrequest = 1'b0;
    tot = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (acc[i]) begin
          m_read[i] = 1'b0;
          acc[i] = 1'b0;
        end
      end
      ddr3_readdatavalid = (beats_left() > 0);
      ddr3_readdata = {8{$urandom}};
      tick();
      tot++;
      if (m_read == '0 && pend < 0 && beats_left() == 0) break;
    end
    ddr3_readdatavalid = 1'b0;
    tick();
    chk("rand_drained", DW'(tot < 400), 1);
    chk("rand_out_0", DW'(outstanding), 0);
    chk("rand_err_0", DW'(err_sticky), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
